hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  ID-stage producer-side partner of the EX-stage forwarding unit. Tracks, per architectural
//  register, how many cycles remain until its newest in-flight value is forwardable. Stalls ID
//  while a source is not yet forwardable (load-use), and cancels tracking when EX is flushed.
//  Also counts stall cycles for performance monitoring.
// PARAMETERS
//  NUM_REGS  32  architectural registers; x0 is never tracked
//  CNT_W     2   width of each per-register countdown
//  ALU_LAT   0   countdown loaded for a non-load writer (0 = fully forwardable)
//  LOAD_LAT  1   countdown loaded for a load writer; must be < 2**CNT_W
// PORTS
//  clk_i          in   1   clock, all state updates on rising edge
//  rst_i          in   1   asynchronous, active-low reset
//  IDValid_i      in   1   valid instruction in ID
//  IDRs1_i        in   5   ID source register 1
//  IDRs2_i        in   5   ID source register 2
//  IDUseRs1_i     in   1   instruction actually reads rs1
//  IDUseRs2_i     in   1   instruction actually reads rs2
//  IDRegWrite_i   in   1   instruction writes rd
//  IDMemRead_i    in   1   instruction is a load
//  IDRd_i         in   5   ID destination register
//  FlushID_i      in   1   squash ID instruction this cycle
//  FlushEX_i      in   1   squash the instruction issued in the previous advancing cycle
//  Freeze_i       in   1   whole pipeline held this cycle, e.g. memory busy
//  Stall_o        out  1   hold PC/IF-ID, insert a bubble into EX
//  Busy_o         out  1   any counter non-zero
//  StallCount_o   out  16  saturating count of cycles with Stall_o=1
// BEHAVIOUR
//  State: cnt[r] (CNT_W bits) for r=1..NUM_REGS-1; EX record exValid, exRd, exShadow (CNT_W).
//  Reset (rst_i=0, async): all cnt=0, exValid=0, exRd=0, exShadow=0, StallCount_o=0.
//   Outputs then: Stall_o=0, Busy_o=0.
//  Hazard, combinational:
//   hz1 = IDUseRs1_i & (IDRs1_i!=0) & (cnt[IDRs1_i]!=0); hz2 is the same for rs2.
//  Stall_o = IDValid_i & ~FlushID_i & ~Freeze_i & (hz1|hz2). Same-cycle, no latency.
//  issue = IDValid_i & ~FlushID_i & ~Freeze_i & ~Stall_o.
//  wr = issue & IDRegWrite_i & (IDRd_i!=0).
//  Freeze_i=1: every counter and the EX record hold; StallCount_o holds.
//   FlushEX_i is still honoured, see below.
//  Advancing cycle (Freeze_i=0), in priority order per register:
//   1. wr: cnt[IDRd_i] <= IDMemRead_i ? LOAD_LAT : ALU_LAT. The issue value beats decrement
//      and beats the flush restore.
//   2. FlushEX_i & exValid & (r==exRd): cnt[r] <= exShadow.
//   3. Otherwise cnt[r] <= (cnt[r]==0) ? 0 : cnt[r]-1.
//  EX record on an advancing cycle:
//   exValid <= wr; exRd <= IDRd_i.
//   exShadow <= dec(cnt[IDRd_i]): the value rd would have had without this issue.
//   When the record is not rewritten, exShadow <= dec(exShadow) in lockstep with the counters.
//  FlushEX_i during Freeze_i: cnt[exRd] <= exShadow, then exValid <= 0.
//   In the advancing case exValid is also cleared unless rewritten by wr.
//  FlushEX_i with exValid=0 has no effect.
//  FlushID_i and Stall_o are mutually exclusive; a flushed ID never issues or counts a stall.
//  StallCount_o increments by 1 on every cycle with Stall_o=1 and saturates at 16'hFFFF.
//  Busy_o = OR of all cnt!=0, taken from registered state.
//  Writes and reads of x0 are ignored everywhere; cnt[0] is constant 0.
//  Same-cycle ordering: hazard check uses pre-edge cnt, so an ID instruction reading the rd of
//   the instruction issuing this same cycle is impossible (it is the same instruction). Back-to-
//   back dependants see the counter next cycle.
// TESTING
//  1. Reset release, idle inputs -> Stall_o=0, Busy_o=0, StallCount_o=0.
//  2. Load x5 issued at T; dependant reading x5 in ID at T+1 -> Stall_o=1 at T+1, 0 at T+2;
//     StallCount_o=1.
//  3. ALU write x7 at T, reader of x7 at T+1 -> Stall_o=0 (ALU_LAT=0).
//     Reader of x0 after load to x0 -> Stall_o=0.
//  4. Load x5 at T with Freeze_i=1 at T+1..T+3, reader of x5 in ID -> Stall_o=0 while frozen,
//     cnt[x5] holds 1. First unfrozen cycle: Stall_o=1. Next cycle: Stall_o=0.
//  5. Load x9 at T, FlushEX_i=1 at T+1 -> cnt[x9]=0 at T+2, reader of x9 not stalled.
//     With an older load still pending on x9, cnt[x9] restores to exShadow instead.
//  6. Force 70000 stall cycles -> StallCount_o saturates at 16'hFFFF.
//     Assert rst_i=0 mid-stall -> all state 0 asynchronously, Stall_o=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage load-use scoreboard: per-register countdown until the newest in-flight value
// becomes forwardable, with EX-flush restore and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDValid_i,
    input  logic [4:0]  IDRs1_i,
    input  logic [4:0]  IDRs2_i,
    input  logic        IDUseRs1_i,
    input  logic        IDUseRs2_i,
    input  logic        IDRegWrite_i,
    input  logic        IDMemRead_i,
    input  logic [4:0]  IDRd_i,
    input  logic        FlushID_i,
    input  logic        FlushEX_i,
    input  logic        Freeze_i,
    output logic        Stall_o,
    output logic        Busy_o,
    output logic [15:0] StallCount_o
);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic [CNT_W-1:0] ex_shadow;

    logic             hz1;
    logic             hz2;
    logic             issue;
    logic             wr;
    logic             restore_en;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        hz1        = IDUseRs1_i && (IDRs1_i != 5'd0) && (cnt[IDRs1_i] != '0);
        hz2        = IDUseRs2_i && (IDRs2_i != 5'd0) && (cnt[IDRs2_i] != '0);
        Stall_o    = IDValid_i && !FlushID_i && !Freeze_i && (hz1 || hz2);
        issue      = IDValid_i && !FlushID_i && !Freeze_i && !Stall_o;
        wr         = issue && IDRegWrite_i && (IDRd_i != 5'd0);
        restore_en = FlushEX_i && ex_valid;
        load_val   = IDMemRead_i ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    end

    always_comb begin
        Busy_o = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            Busy_o = Busy_o | (cnt[r] != '0);
        end
    end

    // A new issue beats the flush restore, which beats the plain decrement; a freeze
    // holds every counter but still lets a flushed EX instruction hand back its register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (!Freeze_i) begin
                    if (wr && (IDRd_i == 5'(r))) begin
                        cnt[r] <= load_val;
                    end else if (restore_en && (ex_rd == 5'(r))) begin
                        cnt[r] <= ex_shadow;
                    end else begin
                        cnt[r] <= dec(cnt[r]);
                    end
                end else if (restore_en && (ex_rd == 5'(r))) begin
                    cnt[r] <= ex_shadow;
                end
            end
        end
    end

    // ex_shadow is the count rd would have had if the EX instruction had never issued.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid  <= 1'b0;
            ex_rd     <= 5'd0;
            ex_shadow <= '0;
        end else if (!Freeze_i) begin
            ex_valid <= wr;
            if (wr) begin
                ex_rd     <= IDRd_i;
                ex_shadow <= dec(cnt[IDRd_i]);
            end else begin
                ex_shadow <= dec(ex_shadow);
            end
        end else if (restore_en) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            StallCount_o <= 16'd0;
        end else if (Stall_o && (StallCount_o != 16'hFFFF)) begin
            StallCount_o <= StallCount_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a ready-time
// model, and a long-latency instance for shadow restore and stall-counter saturation.
module tb_hazard_scoreboard;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main instance (default parameters)
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush_id, flush_ex, freeze;
    logic        stall, busy;
    logic [15:0] stall_count;

    hazard_scoreboard u_dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .IDValid_i    (id_valid),
        .IDRs1_i      (id_rs1),
        .IDRs2_i      (id_rs2),
        .IDUseRs1_i   (id_use_rs1),
        .IDUseRs2_i   (id_use_rs2),
        .IDRegWrite_i (id_reg_write),
        .IDMemRead_i  (id_mem_read),
        .IDRd_i       (id_rd),
        .FlushID_i    (flush_id),
        .FlushEX_i    (flush_ex),
        .Freeze_i     (freeze),
        .Stall_o      (stall),
        .Busy_o       (busy),
        .StallCount_o (stall_count)
    );

    // long-latency instance: 200-cycle loads make nonzero shadows and fast saturation
    logic        s_valid, s_use_rs1, s_reg_write, s_mem_read, s_flush_ex;
    logic [4:0]  s_rs1, s_rd;
    logic        s_stall, s_busy;
    logic [15:0] s_stall_count;

    hazard_scoreboard #(.CNT_W(8), .LOAD_LAT(200)) u_sat (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .IDValid_i    (s_valid),
        .IDRs1_i      (s_rs1),
        .IDRs2_i      (5'd0),
        .IDUseRs1_i   (s_use_rs1),
        .IDUseRs2_i   (1'b0),
        .IDRegWrite_i (s_reg_write),
        .IDMemRead_i  (s_mem_read),
        .IDRd_i       (s_rd),
        .FlushID_i    (1'b0),
        .FlushEX_i    (s_flush_ex),
        .Freeze_i     (1'b0),
        .Stall_o      (s_stall),
        .Busy_o       (s_busy),
        .StallCount_o (s_stall_count)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each register holds the advance-count at which it becomes
    // forwardable; frozen cycles do not advance, so remaining = ready - adv.
    int ready [32];
    int adv;
    bit m_ex_valid;
    int m_ex_rd;
    int m_ex_shadow;
    int m_count;

    logic        obs_stall, obs_busy;
    logic [15:0] obs_count;

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (ready[r] > adv) ? ready[r] - adv : 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        adv = 0;
        m_ex_valid = 0;
        m_ex_rd = 0;
        m_ex_shadow = 0;
        m_count = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input bit rw, input bit mr, input int rd,
                         input bit fid, input bit fex, input bit frz);
        id_valid = v;       id_rs1 = 5'(rs1);  id_use_rs1 = u1;
        id_rs2 = 5'(rs2);   id_use_rs2 = u2;   id_reg_write = rw;
        id_mem_read = mr;   id_rd = 5'(rd);
        flush_id = fid;     flush_ex = fex;    freeze = frz;
    endtask

    task automatic s_drive(input bit v, input int rs1, input bit u1, input bit rw, input bit mr,
                           input int rd, input bit fex);
        s_valid = v;  s_rs1 = 5'(rs1);  s_use_rs1 = u1;  s_reg_write = rw;
        s_mem_read = mr;  s_rd = 5'(rd);  s_flush_ex = fex;
    endtask

    // One clock of the main instance: compare at negedge, advance the model, pass the edge.
    task automatic step(input string tag);
        bit hz1, hz2, e_stall, iss, wr, e_busy;
        int r1, r2, rd, sh, new_adv;
        @(negedge clk);
        r1 = int'(id_rs1);
        r2 = int'(id_rs2);
        rd = int'(id_rd);
        e_busy = 0;
        for (int r = 1; r < 32; r++) if (rem(r) != 0) e_busy = 1;
        hz1 = id_use_rs1 && (r1 != 0) && (rem(r1) != 0);
        hz2 = id_use_rs2 && (r2 != 0) && (rem(r2) != 0);
        e_stall = id_valid && !flush_id && !freeze && (hz1 || hz2);
        iss = id_valid && !flush_id && !freeze && !e_stall;
        wr = iss && id_reg_write && (rd != 0);
        obs_stall = stall;
        obs_busy  = busy;
        obs_count = stall_count;
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".count"}, 32'(stall_count), 32'(m_count));
        if (!freeze) begin
            new_adv = adv + 1;
            sh = (rem(rd) > 0) ? rem(rd) - 1 : 0;
            if (flush_ex && m_ex_valid) ready[m_ex_rd] = new_adv + m_ex_shadow;
            if (wr) begin
                ready[rd] = new_adv + (id_mem_read ? 1 : 0);
                m_ex_valid = 1;
                m_ex_rd = rd;
                m_ex_shadow = sh;
            end else begin
                m_ex_valid = 0;
            end
            adv = new_adv;
        end else if (flush_ex && m_ex_valid) begin
            ready[m_ex_rd] = adv + m_ex_shadow;
            m_ex_valid = 0;
        end
        if (e_stall && m_count < 65535) m_count++;
        tick();
    endtask

    // ---------------- stimulus ----------------
    int exp_sat;
    int n;
    bit done;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state with idle inputs
        step("reset0");
        check("reset_stall", 32'(obs_stall), 32'd0);
        check("reset_busy", 32'(obs_busy), 32'd0);
        check("reset_count", 32'(obs_count), 32'd0);
        step("reset1");

        // load-use on x5
        drive(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0);  step("lu_load");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("lu_dep0");
        check("lu_stall_t1", 32'(obs_stall), 32'd1);
        step("lu_dep1");
        check("lu_stall_t2", 32'(obs_stall), 32'd0);
        check("lu_count", 32'(obs_count), 32'd1);

        // ALU producer forwards immediately; x0 never tracked
        drive(1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);  step("alu_wr");
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);  step("alu_rd");
        check("alu_no_stall", 32'(obs_stall), 32'd0);
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);  step("x0_load");
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);  step("x0_rd");
        check("x0_no_stall", 32'(obs_stall), 32'd0);
        check("x0_not_busy", 32'(obs_busy), 32'd0);

        // freeze holds the countdown and suppresses the stall
        drive(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0);  step("frz_load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            step($sformatf("frz_hold%0d", i));
            check($sformatf("frz_stall%0d", i), 32'(obs_stall), 32'd0);
            check($sformatf("frz_busy%0d", i), 32'(obs_busy), 32'd1);
        end
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("frz_release");
        check("frz_first_stall", 32'(obs_stall), 32'd1);
        step("frz_after");
        check("frz_after_stall", 32'(obs_stall), 32'd0);

        // flushed ID neither stalls nor counts
        drive(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0);  step("fid_load");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);  step("fid_rd");
        check("fid_no_stall", 32'(obs_stall), 32'd0);

        // FlushEX cancels a load, advancing and during a freeze
        drive(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0);  step("fex_load");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("fex_flush");
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("fex_rd");
        check("fex_no_stall", 32'(obs_stall), 32'd0);
        drive(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0);  step("fexz_load");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  step("fexz_flush");
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);  step("fexz_rd");
        check("fexz_no_stall", 32'(obs_stall), 32'd0);
        check("fexz_not_busy", 32'(obs_busy), 32'd0);

        // random traffic over a small register window
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0);
            step($sformatf("rnd%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // flush restores an older pending load's remaining count
        s_drive(1, 0, 0, 1, 1, 9, 0);  tick();
        s_drive(1, 0, 0, 1, 1, 9, 0);  tick();
        s_drive(0, 0, 0, 0, 0, 0, 1);  tick();
        s_drive(1, 9, 1, 0, 0, 0, 0);
        n = 0;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (k == 0) check("shadow_busy", 32'(s_busy), 32'd1);
            if (s_stall) n++;
            else done = 1;
            tick();
        end
        check("shadow_done", 32'(done), 32'd1);
        check("shadow_stalls", 32'(n), 32'd199);
        exp_sat = 199;
        s_drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("shadow_count", 32'(s_stall_count), 32'(exp_sat));

        // saturate the stall counter: each burst is a load then 200 stalled cycles
        for (int b = 0; b < 330; b++) begin
            s_drive(1, 0, 0, 1, 1, 3, 0);  tick();
            s_drive(1, 3, 1, 0, 0, 0, 0);
            for (int k = 0; k <= 200; k++) begin
                if (b == 0) begin
                    @(negedge clk);
                    check($sformatf("burst0_k%0d", k), 32'(s_stall), 32'(k < 200));
                end
                tick();
            end
            exp_sat = (exp_sat + 200 > 65535) ? 65535 : exp_sat + 200;
            @(negedge clk);
            if (b == 0) check("burst0_count", 32'(s_stall_count), 32'(exp_sat));
        end
        check("sat_count", 32'(s_stall_count), 32'(exp_sat));
        check("sat_ffff", 32'(s_stall_count), 32'h0000_FFFF);

        // asynchronous reset in the middle of a stall
        s_drive(1, 0, 0, 1, 1, 3, 0);  tick();
        s_drive(1, 3, 1, 0, 0, 0, 0);  tick();
        @(posedge clk);
        #2;
        check("pre_rst_stall", 32'(s_stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_sat_stall", 32'(s_stall), 32'd0);
        check("rst_sat_busy", 32'(s_busy), 32'd0);
        check("rst_sat_count", 32'(s_stall_count), 32'd0);
        check("rst_main_busy", 32'(busy), 32'd0);
        check("rst_main_count", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
